// File: rtl/matrixmul_mac_sched.sv
`default_nettype none
// ============================================================================
// Module      : matrixmul_mac_sched
// Description : Sequencer for a DIM x DIM signed matrix multiply C = A x B.
//               Walks i/j/k (k innermost), issues A/B memory reads, feeds the
//               external multiplier one operand pair per cycle, accumulates
//               DIM products per element and writes C in row-major order.
//               Block-level ap_start/ap_done handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   ap_clk, ap_rst            clock, asynchronous active-high reset
//   ap_start                  start request (sampled only in IDLE)
//   ap_done, ap_ready         one-cycle pulse after the last result write
//   ap_idle                   high while idle
//   a_address0/a_ce0/a_q0     A read port (i*DIM+k), data one cycle later
//   b_address0/b_ce0/b_q0     B read port (k*DIM+j), data one cycle later
//   mul_din0/mul_din1         operands to the external multiplier
//   mul_dout                  product from the external multiplier (comb)
//   res_address0/res_ce0/
//   res_we0/res_d0            C write port (i*DIM+j)
// ============================================================================
module matrixmul_mac_sched #(
  parameter int DIM   = 3,
  parameter int AW    = 4,
  parameter int A_W   = 8,
  parameter int B_W   = 6,
  parameter int P_W   = 8,
  parameter int RES_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic [AW-1:0]    a_address0,
  output logic             a_ce0,
  input  logic [A_W-1:0]   a_q0,
  output logic [AW-1:0]    b_address0,
  output logic             b_ce0,
  input  logic [B_W-1:0]   b_q0,
  output logic [A_W-1:0]   mul_din0,
  output logic [B_W-1:0]   mul_din1,
  input  logic [P_W-1:0]   mul_dout,
  output logic [AW-1:0]    res_address0,
  output logic             res_ce0,
  output logic             res_we0,
  output logic [RES_W-1:0] res_d0
);

  localparam int            IW     = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IW-1:0] c_LAST = IW'(DIM - 1);
  localparam logic [AW-1:0] c_DIM  = AW'(DIM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_issue;
  logic             w_done;
  logic             w_idle;
  logic             w_last_issue;
  logic             r_drain_cnt;

  // issue-stage indices
  logic [IW-1:0]    r_i;
  logic [IW-1:0]    r_j;
  logic [IW-1:0]    r_k;

  // stage 1: operand data returning from memory, indices carried alongside
  logic             r_s1_valid;
  logic [IW-1:0]    r_i1;
  logic [IW-1:0]    r_j1;
  logic [IW-1:0]    r_k1;

  // stage 2: completed element ready to be written
  logic             r_s2_valid;
  logic [AW-1:0]    r_res_addr;

  logic [RES_W-1:0] r_acc;
  logic [RES_W-1:0] w_prod_ext;

  assign w_last_issue = (r_state == S_RUN) && (r_i == c_LAST) &&
                        (r_j == c_LAST) && (r_k == c_LAST);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_idle      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle = 1'b1;
        if (ap_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // two cycles: let the last operands pass stage 1 and stage 2
        if (r_drain_cnt) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_drain_cnt <= 1'b0;
    end else begin
      r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Index walker: k innermost, then j, then i. Wraps back to all-zero after
  // the final issue, so the next run starts clean.
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (w_issue) begin
      if (r_k == c_LAST) begin
        r_k <= '0;
        if (r_j == c_LAST) begin
          r_j <= '0;
          r_i <= (r_i == c_LAST) ? '0 : r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end else begin
        r_k <= r_k + 1'b1;
      end
    end else begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline stages
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_s1_valid <= 1'b0;
      r_i1       <= '0;
      r_j1       <= '0;
      r_k1       <= '0;
      r_s2_valid <= 1'b0;
      r_res_addr <= '0;
    end else begin
      r_s1_valid <= w_issue;
      r_i1       <= r_i;
      r_j1       <= r_j;
      r_k1       <= r_k;
      r_s2_valid <= r_s1_valid && (r_k1 == c_LAST);
      r_res_addr <= c_DIM * AW'(r_i1) + AW'(r_j1);
    end
  end

  // Product is sign-extended (or truncated) to the accumulator width; the
  // accumulator wraps modulo 2^RES_W.
  assign w_prod_ext = RES_W'($signed(mul_dout));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc <= '0;
    end else if (r_s1_valid) begin
      // first product of an element restarts the sum
      r_acc <= ((r_k1 == '0) ? '0 : r_acc) + w_prod_ext;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: everything gated by its stage valid so idle/reset drives zeros.
  // Stage 2 reads the accumulator while stage 1 may already be restarting it;
  // the new sum only lands at the end of that cycle.
  // --------------------------------------------------------------------------
  assign ap_idle      = w_idle;
  assign ap_done      = w_done;
  assign ap_ready     = w_done;

  assign a_ce0        = w_issue;
  assign b_ce0        = w_issue;
  assign a_address0   = w_issue ? (c_DIM * AW'(r_i) + AW'(r_k)) : '0;
  assign b_address0   = w_issue ? (c_DIM * AW'(r_k) + AW'(r_j)) : '0;

  assign mul_din0     = r_s1_valid ? a_q0 : '0;
  assign mul_din1     = r_s1_valid ? b_q0 : '0;

  assign res_ce0      = r_s2_valid;
  assign res_we0      = r_s2_valid;
  assign res_address0 = r_s2_valid ? r_res_addr : '0;
  assign res_d0       = r_s2_valid ? r_acc : '0;

endmodule
`default_nettype wire

// File: tb/tb_matrixmul_mac_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrixmul_mac_sched
// Description : Scoreboard bench for matrixmul_mac_sched. Two instances share
//               the A/B memory contents: one with a 16-bit accumulator and one
//               with an 8-bit accumulator (wrap behaviour). Expected writes
//               and ap_done cycles are computed from C = A x B with plain
//               integer arithmetic and queued at start; a monitor pops them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrixmul_mac_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ap_start = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [7:0] mem_a [0:15];
  logic signed [5:0] mem_b [0:15];

  // ---------------- DUT with RES_W=16 ----------------
  logic        ap_done, ap_idle, ap_ready, a_ce0, b_ce0, res_ce0, res_we0;
  logic [3:0]  a_address0, b_address0, res_address0;
  logic [7:0]  a_q0, mul_din0, mul_dout;
  logic [5:0]  b_q0, mul_din1;
  logic [15:0] res_d0;
  logic signed [13:0] w_full;

  matrixmul_mac_sched #(.DIM(3), .AW(4), .A_W(8), .B_W(6), .P_W(8), .RES_W(16)) dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .a_address0(a_address0), .a_ce0(a_ce0), .a_q0(a_q0),
    .b_address0(b_address0), .b_ce0(b_ce0), .b_q0(b_q0),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_address0(res_address0), .res_ce0(res_ce0), .res_we0(res_we0), .res_d0(res_d0)
  );

  always @(posedge clk) begin
    if (a_ce0) a_q0 <= mem_a[a_address0];
    if (b_ce0) b_q0 <= mem_b[b_address0];
  end
  assign w_full   = $signed(mul_din0) * $signed(mul_din1);
  assign mul_dout = w_full[7:0];

  // ---------------- DUT with RES_W=8 ----------------
  logic        ap_done8, ap_idle8, ap_ready8, a_ce08, b_ce08, res_ce08, res_we08;
  logic [3:0]  a_address08, b_address08, res_address08;
  logic [7:0]  a_q08, mul_din08, mul_dout8;
  logic [5:0]  b_q08, mul_din18;
  logic [7:0]  res_d08;
  logic signed [13:0] w_full8;

  matrixmul_mac_sched #(.DIM(3), .AW(4), .A_W(8), .B_W(6), .P_W(8), .RES_W(8)) dut8 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start),
    .ap_done(ap_done8), .ap_idle(ap_idle8), .ap_ready(ap_ready8),
    .a_address0(a_address08), .a_ce0(a_ce08), .a_q0(a_q08),
    .b_address0(b_address08), .b_ce0(b_ce08), .b_q0(b_q08),
    .mul_din0(mul_din08), .mul_din1(mul_din18), .mul_dout(mul_dout8),
    .res_address0(res_address08), .res_ce0(res_ce08), .res_we0(res_we08), .res_d0(res_d08)
  );

  always @(posedge clk) begin
    if (a_ce08) a_q08 <= mem_a[a_address08];
    if (b_ce08) b_q08 <= mem_b[b_address08];
  end
  assign w_full8   = $signed(mul_din08) * $signed(mul_din18);
  assign mul_dout8 = w_full8[7:0];

  // ---------------- scoreboard ----------------
  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   done_q[$];
  int   run_from = -100;   // first busy cycle of the latest run
  int   run_to   = -100;   // ap_done cycle of the latest run
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: C[i][j] = sum_k trunc8(A[i][k]*B[k][j]) per element,
  // written row-major one every 3 cycles starting 5 cycles after start.
  task automatic push_run(input int t);
    int p, s;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) begin
          p = (int'(mem_a[i*3+k]) * int'(mem_b[k*3+j])) & 255;
          if (p >= 128) p -= 256;
          s += p;
        end
        e.addr = i*3 + j;
        e.cyc  = t + 5 + 3*(i*3 + j);
        e.data = s & 16'hFFFF;
        q16.push_back(e);
        e.data = s & 8'hFF;
        q8.push_back(e);
      end
    end
    done_q.push_back(t + 30);
    run_from = t + 1;
    run_to   = t + 30;
  endtask

  // Monitor: samples 2 time units after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    bit   exp_busy;
    #2;
    exp_busy = !rst && (cyc >= run_from) && (cyc <= run_to);
    chk("ap_idle", int'(ap_idle), int'(!exp_busy));
    chk("ap_idle8", int'(ap_idle8), int'(!exp_busy));
    chk("ap_ready_eq_done", int'(ap_ready), int'(ap_done));
    chk("ap_ready8_eq_done8", int'(ap_ready8), int'(ap_done8));
    chk("ab_ce_window", int'({a_ce0, b_ce0}),
        (!rst && cyc >= run_from && cyc <= run_from + 26) ? 3 : 0);
    if (!(cyc >= run_from + 1 && cyc <= run_from + 27))
      chk("mul_din_zero", int'({mul_din0, mul_din1}), 0);
    if (res_ce0 || res_we0) begin
      chk("res_ce_eq_we", int'(res_ce0), int'(res_we0));
      if (q16.size() == 0) begin
        chk("res_unexpected_write", 1, 0);
      end else begin
        e = q16.pop_front();
        chk("res_addr", int'(res_address0), e.addr);
        chk("res_data", int'(res_d0), e.data);
        chk("res_cycle", cyc, e.cyc);
      end
    end
    if (res_ce08 || res_we08) begin
      if (q8.size() == 0) begin
        chk("res8_unexpected_write", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("res8_addr", int'(res_address08), e.addr);
        chk("res8_data", int'(res_d08), e.data);
        chk("res8_cycle", cyc, e.cyc);
      end
    end
    chk("ap_done8_eq_done", int'(ap_done8), int'(ap_done));
    if (ap_done) begin
      if (done_q.size() == 0) chk("ap_done_unexpected", 1, 0);
      else chk("ap_done_cycle", cyc, done_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill(input int mode, input int av, input int bv);
    for (int x = 0; x < 16; x++) begin
      case (mode)
        0: begin mem_a[x] = 8'(av); mem_b[x] = 6'(bv); end
        1: begin mem_a[x] = (x == 0 || x == 4 || x == 8) ? 8'sd1 : 8'sd0;
                 mem_b[x] = 6'(x - 4); end
        default: begin mem_a[x] = 8'($urandom); mem_b[x] = 6'($urandom); end
      endcase
    end
  endtask

  task automatic run_basic(input bit extra_pulse);
    int t;
    @(negedge clk);
    ap_start = 1'b1;
    t = cyc;
    push_run(t);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      ap_start = extra_pulse && (cyc == t + 10);
    end
  endtask

  task automatic run_held;
    int t;
    @(negedge clk);
    ap_start = 1'b1;
    t = cyc;
    push_run(t);
    for (int c = 1; c <= 31; c++) @(negedge clk);
    push_run(t + 31);                       // accepted in first idle cycle
    @(negedge clk);
    ap_start = 1'b0;
    for (int c = 1; c <= 32; c++) @(negedge clk);
  endtask

  task automatic run_reset_mid;
    int t;
    exp_t keep16[$];
    exp_t keep8[$];
    @(negedge clk);
    ap_start = 1'b1;
    t = cyc;
    push_run(t);
    @(negedge clk);
    ap_start = 1'b0;
    for (int c = 2; c <= 15; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ap_idle", int'(ap_idle), 1);
    chk("rst_ap_done", int'(ap_done), 0);
    chk("rst_a_ce0", int'(a_ce0), 0);
    chk("rst_a_addr", int'(a_address0), 0);
    chk("rst_res_we0", int'(res_we0 | res_ce0), 0);
    chk("rst_res_d0", int'(res_d0), 0);
    chk("rst_mul_din", int'({mul_din0, mul_din1}), 0);
    foreach (q16[n]) if (q16[n].cyc <= t + 15) keep16.push_back(q16[n]);
    foreach (q8[n])  if (q8[n].cyc  <= t + 15) keep8.push_back(q8[n]);
    q16 = keep16;
    q8  = keep8;
    done_q.delete();
    run_from = -100;
    run_to   = -100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_basic(1'b0);
  endtask

  initial begin
    fill(0, 0, 0);
    #1;
    chk("reset_ap_idle", int'(ap_idle), 1);
    chk("reset_outputs", int'({ap_done, ap_ready, a_ce0, b_ce0, res_ce0, res_we0}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    fill(0, 1, 1);      run_basic(1'b0);   // C all 3
    fill(1, 0, 0);      run_basic(1'b0);   // identity: C = B
    fill(0, 100, 3);    run_basic(1'b0);   // product 44, C 132
    fill(0, -128, -32); run_basic(1'b0);   // product 0
    fill(0, 127, 31);   run_basic(1'b0);   // 291 / 35 with 8-bit acc
    for (int r = 0; r < 3; r++) begin
      fill(2, 0, 0);    run_basic(1'b0);
    end
    fill(2, 0, 0);      run_basic(1'b1);   // start pulse during RUN ignored
    fill(2, 0, 0);      run_held();        // back-to-back runs
    fill(2, 0, 0);      run_reset_mid();   // abort and restart

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q16.size() + q8.size() + done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
